// File: rtl/kp_color_bbox.sv
// -----------------------------------------------------------------------------
// kp_color_bbox
//
// Colour-threshold detector placed after the Gaussian filter stage. It drains
// the upstream RGB565 output buffer, classifies every pixel against inclusive
// per-channel min/max thresholds and emits either a binary mask stream
// (enabled) or the unmodified pixel (passthrough). While enabled it tracks
// the match count and bounding box of matching pixels over a frame and
// latches those results at the end of the frame for the host register layer.
//
// Optional build macro:
//   KP_BBOX_OVERLAY_EN  - when defined, enabled output is the original pixel
//                         with the last completed frame's bbox border drawn
//                         in red (16'hF800) instead of the binary mask.
//
// Ports:
//   i_clk, i_rstn        clock, synchronous active-low reset
//   i_enable             1 = detect, 0 = passthrough (stats held at 0)
//   i_flush              drain upstream, clear pipeline/counters/stats
//   i_data               pixel from upstream buffer (valid cycle after o_rd)
//   i_almostempty        upstream buffer almost empty
//   o_rd                 upstream read strobe
//   i_almostfull         downstream buffer almost full (backpressure)
//   i_rmin..i_bmax       inclusive colour thresholds, sampled live
//   o_data, o_valid      output pixel stream (downstream write strobe)
//   o_xmin..o_ymax       bbox of last completed frame
//   o_count, o_found     match count / any-match of last completed frame
//   o_frame_done         one-cycle pulse when the results above update
// -----------------------------------------------------------------------------
module kp_color_bbox #(
    parameter int LINE_LENGTH = 480,
    parameter int LINE_COUNT  = 480,
    parameter int DATA_WIDTH  = 16,
    localparam int XW = $clog2(LINE_LENGTH),
    localparam int YW = $clog2(LINE_COUNT),
    localparam int CW = $clog2(LINE_LENGTH * LINE_COUNT + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_almostempty,
    output logic                  o_rd,
    input  logic                  i_almostfull,
    input  logic [4:0]            i_rmin,
    input  logic [4:0]            i_rmax,
    input  logic [5:0]            i_gmin,
    input  logic [5:0]            i_gmax,
    input  logic [4:0]            i_bmin,
    input  logic [4:0]            i_bmax,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [XW-1:0]         o_xmin,
    output logic [XW-1:0]         o_xmax,
    output logic [YW-1:0]         o_ymin,
    output logic [YW-1:0]         o_ymax,
    output logic [CW-1:0]         o_count,
    output logic                  o_found,
    output logic                  o_frame_done
);

    localparam logic [XW-1:0] X_LAST = XW'(LINE_LENGTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(LINE_COUNT - 1);

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state_reg, state_next;
    logic   rd_reg, rd_next;
    logic   go;

    assign go = !i_almostempty && !i_almostfull;

    always_comb begin
        state_next = state_reg;
        rd_next    = 1'b0;
        case (state_reg)
            IDLE:    if (go)  state_next = ACTIVE;
            ACTIVE:  if (!go) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        rd_next = (state_next == ACTIVE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_flush) begin
            state_reg <= IDLE;
            rd_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            rd_reg    <= rd_next;
        end
    end

    // Flush reads unconditionally so upstream drains; those words are dropped.
    assign o_rd = rd_reg | i_flush;

    // Upstream data arrives one cycle after the strobe. Reads issued by the
    // flush override never set din_valid_reg (rd_reg is held low).
    logic din_valid_reg;
    logic din_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_flush) begin
            din_valid_reg <= 1'b0;
        end else begin
            din_valid_reg <= rd_reg;
        end
    end

    assign din_valid = din_valid_reg && !i_flush;

    // ------------------------------------------------------------------
    // Classification
    // ------------------------------------------------------------------
    logic [4:0] pix_r;
    logic [5:0] pix_g;
    logic [4:0] pix_b;
    logic       match;

    assign pix_r = i_data[15:11];
    assign pix_g = i_data[10:5];
    assign pix_b = i_data[4:0];

    // An inverted range (min > max) can never satisfy both compares.
    assign match = (pix_r >= i_rmin) && (pix_r <= i_rmax) &&
                   (pix_g >= i_gmin) && (pix_g <= i_gmax) &&
                   (pix_b >= i_bmin) && (pix_b <= i_bmax);

    // ------------------------------------------------------------------
    // Position and running statistics
    // ------------------------------------------------------------------
    logic [XW-1:0] x_reg, y_dummy_unused_x;
    logic [YW-1:0] y_reg;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [XW-1:0] xmin_reg, xmax_reg, xmin_next, xmax_next;
    logic [YW-1:0] ymin_reg, ymax_reg, ymin_next, ymax_next;

    logic pix_en, hit, eof;

    assign y_dummy_unused_x = '0;
    assign pix_en = din_valid && i_enable;
    assign hit    = pix_en && match;
    assign eof    = pix_en && (x_reg == X_LAST) && (y_reg == Y_LAST);

    // Stats including the current pixel; used both for the running update
    // and for the end-of-frame latch so the last pixel is counted.
    always_comb begin
        cnt_next  = cnt_reg;
        xmin_next = xmin_reg;
        xmax_next = xmax_reg;
        ymin_next = ymin_reg;
        ymax_next = ymax_reg;
        if (hit) begin
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == '0) begin
                // First match of the frame seeds the box.
                xmin_next = x_reg;
                xmax_next = x_reg;
                ymin_next = y_reg;
                ymax_next = y_reg;
            end else begin
                if (x_reg < xmin_reg) xmin_next = x_reg;
                if (x_reg > xmax_reg) xmax_next = x_reg;
                if (y_reg < ymin_reg) ymin_next = y_reg;
                if (y_reg > ymax_reg) ymax_next = y_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    logic [XW-1:0] res_xmin_reg, res_xmax_reg;
    logic [YW-1:0] res_ymin_reg, res_ymax_reg;
    logic [CW-1:0] res_count_reg;
    logic          res_found_reg;
    logic          frame_done_reg;

    // ------------------------------------------------------------------
    // Output pixel
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] pix_out;

`ifdef KP_BBOX_OVERLAY_EN
    logic in_x, in_y, on_col, on_row, border;

    assign in_x   = (x_reg >= res_xmin_reg) && (x_reg <= res_xmax_reg);
    assign in_y   = (y_reg >= res_ymin_reg) && (y_reg <= res_ymax_reg);
    assign on_col = (x_reg == res_xmin_reg) || (x_reg == res_xmax_reg);
    assign on_row = (y_reg == res_ymin_reg) || (y_reg == res_ymax_reg);
    assign border = res_found_reg && ((on_col && in_y) || (on_row && in_x));

    always_comb begin
        pix_out = i_data;
        if (i_enable && border) pix_out = DATA_WIDTH'(16'hF800);
    end
`else
    always_comb begin
        pix_out = i_data;
        if (i_enable) pix_out = match ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    end
`endif

    logic [DATA_WIDTH-1:0] data_reg;
    logic                  valid_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            x_reg          <= '0;
            y_reg          <= '0;
            cnt_reg        <= '0;
            xmin_reg       <= '0;
            xmax_reg       <= '0;
            ymin_reg       <= '0;
            ymax_reg       <= '0;
            res_xmin_reg   <= '0;
            res_xmax_reg   <= '0;
            res_ymin_reg   <= '0;
            res_ymax_reg   <= '0;
            res_count_reg  <= '0;
            res_found_reg  <= 1'b0;
        end else begin
            valid_reg      <= din_valid;
            frame_done_reg <= eof;
            if (din_valid) data_reg <= pix_out;

            if (i_flush || !i_enable) begin
                // Partial frame is discarded; results stay latched.
                x_reg    <= '0;
                y_reg    <= '0;
                cnt_reg  <= '0;
                xmin_reg <= '0;
                xmax_reg <= '0;
                ymin_reg <= '0;
                ymax_reg <= '0;
            end else if (din_valid) begin
                if (x_reg == X_LAST) begin
                    x_reg <= '0;
                    y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + YW'(1);
                end else begin
                    x_reg <= x_reg + XW'(1);
                end

                if (eof) begin
                    res_count_reg <= cnt_next;
                    res_xmin_reg  <= xmin_next;
                    res_xmax_reg  <= xmax_next;
                    res_ymin_reg  <= ymin_next;
                    res_ymax_reg  <= ymax_next;
                    res_found_reg <= (cnt_next != '0);
                    cnt_reg       <= '0;
                    xmin_reg      <= '0;
                    xmax_reg      <= '0;
                    ymin_reg      <= '0;
                    ymax_reg      <= '0;
                end else begin
                    cnt_reg  <= cnt_next;
                    xmin_reg <= xmin_next;
                    xmax_reg <= xmax_next;
                    ymin_reg <= ymin_next;
                    ymax_reg <= ymax_next;
                end
            end
        end
    end

    assign o_data       = data_reg;
    assign o_valid      = valid_reg;
    assign o_frame_done = frame_done_reg;
    assign o_xmin       = res_xmin_reg;
    assign o_xmax       = res_xmax_reg;
    assign o_ymin       = res_ymin_reg;
    assign o_ymax       = res_ymax_reg;
    assign o_count      = res_count_reg;
    assign o_found      = res_found_reg;

endmodule

// File: doc/kp_color_bbox.md
Name: kp_color_bbox

Overview:
- Downstream of the Gaussian filter stage. Drains that stage's RGB565 output buffer.
- Classifies each pixel against per-channel min/max colour thresholds and emits a binary mask pixel stream.
- Accumulates per-frame match count and bounding box of matching pixels; latches the results at end of frame for the host/AXI register layer.

Parameters:
- LINE_LENGTH, 480, pixels per line
- LINE_COUNT, 480, lines per frame
- DATA_WIDTH, 16, pixel width (RGB565: R[15:11] G[10:5] B[4:0])

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_enable  in  1  detect enable; 0 = passthrough
- i_flush  in  1  drain upstream and clear pipeline/counters/stats
- i_data  in  DATA_WIDTH  pixel from upstream output buffer
- i_almostempty  in  1  upstream buffer almost-empty
- o_rd  out  1  upstream buffer read strobe
- i_almostfull  in  1  downstream buffer almost-full (backpressure)
- i_rmin, i_rmax  in  5  red thresholds, inclusive
- i_gmin, i_gmax  in  6  green thresholds, inclusive
- i_bmin, i_bmax  in  5  blue thresholds, inclusive
- o_data  out  DATA_WIDTH  output pixel
- o_valid  out  1  o_data valid (downstream write strobe)
- o_xmin, o_xmax  out  $clog2(LINE_LENGTH)  bbox columns, last completed frame
- o_ymin, o_ymax  out  $clog2(LINE_COUNT)  bbox rows, last completed frame
- o_count  out  $clog2(LINE_LENGTH*LINE_COUNT+1)  matching pixels, last frame
- o_found  out  1  last frame had at least one match
- o_frame_done  out  1  one-cycle pulse when results update

Behaviour:
- Reset (i_rstn=0): every output is 0, FSM is IDLE, and pixel x/y counters and running stats are 0.
- Read FSM, states IDLE and ACTIVE:
  - IDLE->ACTIVE when !i_almostempty && !i_almostfull.
  - ACTIVE->IDLE when i_almostempty || i_almostfull.
  - o_rd is registered and equals the "go" condition, so it is high in every ACTIVE cycle.
- Read latency: i_data is valid the cycle after o_rd (internal din_valid = o_rd delayed one cycle).
- Output timing: a pixel sampled in cycle T appears on o_data/o_valid at T+1. Throughput is 1 pixel/clock.
- Match rule: match = (rmin<=R<=rmax) && (gmin<=G<=gmax) && (bmin<=B<=bmax). If min>max on any channel, nothing matches. Thresholds are sampled live.
- Output pixel, i_enable=1: match ? 16'hFFFF : 16'h0000.
- Output pixel, i_enable=0: i_data is passed through unchanged, with the same latency.
- Position counters: x increments per valid pixel and wraps at LINE_LENGTH-1 to 0, incrementing y. y wraps at LINE_COUNT-1 to 0.
- Running stats (enabled only), per match:
  - count += 1
  - xmin/ymin take the min with the current position; xmax/ymax take the max.
  - The first match of a frame loads all four bbox values directly.
- End of frame (valid pixel at x=LINE_LENGTH-1, y=LINE_COUNT-1, enabled):
  - At T+1, the output registers load the running stats including that last pixel.
  - At T+1, o_found = (count>0) and o_frame_done pulses; running stats clear the same cycle.
  - No match in the frame: o_count=0, o_found=0, bbox outputs 0.
- i_enable=0: counters and running stats are held at 0, o_frame_done never pulses, and the output registers keep their last values.
  - i_enable falling mid-frame discards the partial frame.
  - i_enable rising starts a new frame at x=y=0.
- i_flush:
  - o_rd is forced to 1 every flush cycle.
  - din_valid is suppressed, so o_valid=0.
  - Counters, running stats and FSM are cleared; the output result registers are retained.
- Backpressure: up to 2 pixels may still arrive after i_almostfull rises. The downstream buffer provides an ALMOSTFULL_OFFSET of at least 2.

Optional Feature:
- Macro KP_BBOX_OVERLAY_EN.
- Defined: when enabled, o_data is the original pixel, replaced by 16'hF800 (red) on the bbox border of the last completed frame when o_found=1.
  - Border = (x==xmin||x==xmax) && ymin<=y<=ymax, or (y==ymin||y==ymax) && xmin<=x<=xmax.
- Undefined: binary mask output as above; no overlay logic.

Test Plan (LINE_LENGTH=4, LINE_COUNT=3):
- Reset with i_almostempty=0 -> o_rd=0, o_valid=0, all results 0; release reset -> o_rd=1 next cycle, first o_valid two cycles after the first o_rd.
- i_enable=0, stream 16'h1234 -> o_data=16'h1234 one cycle after sampling; o_frame_done stays 0.
- Thresholds R[20,31] G[0,63] B[0,31]; 12 pixels, 16'hF800 at (1,0) and (3,2), others 0 -> mask FFFF at those two pixels; o_frame_done pulse; o_count=2, xmin=1, xmax=3, ymin=0, ymax=2, o_found=1.
- Frame with no matches -> o_count=0, o_found=0, bbox outputs 0.
- i_almostfull asserted mid-line -> o_rd drops the next cycle, at most 2 further o_valid, then resume with no pixel lost or duplicated (x/y continuity checked).
- i_flush for 3 cycles mid-frame -> o_rd=1 throughout, o_valid=0; next frame starts at x=y=0; previous results unchanged.
